// File: rtl/nand_ctrl_pkg.sv
// Shared definitions for the NAND-style control path: sequencer states,
// instruction field bit positions and the datapath word width.
package nand_ctrl_pkg;

    localparam int WIDTH  = 16;

    // Instruction field bit positions
    localparam int CI     = 15;  // 1 = compute instruction, 0 = data instruction
    localparam int SM     = 12;  // ALU operand select (*A instead of A)
    localparam int ALU_HI = 10;  // ALU control field, upper bit
    localparam int ALU_LO = 6;   // ALU control field, lower bit
    localparam int DST_A  = 5;   // store to A
    localparam int DST_D  = 4;   // store to D
    localparam int DST_M  = 3;   // store to *A
    localparam int J_LT   = 2;   // jump if result < 0
    localparam int J_EQ   = 1;   // jump if result == 0
    localparam int J_GT   = 0;   // jump if result > 0

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        EVAL  = 2'd1,
        WRITE = 2'd2,
        HALT  = 2'd3
    } state_e;

endpackage

// File: rtl/nand_jump_cond.sv
// Jump condition evaluation: combines the three jump-enable bits of a
// compute instruction with the sign/zero status of the ALU result
// (treated as two's-complement signed).
// Ports:
//   j_lt, j_eq, j_gt : jump enables from the instruction word
//   alu_r            : ALU result
//   jmp              : 1 when the selected condition holds
module nand_jump_cond
    import nand_ctrl_pkg::*;
(
    input  logic             j_lt,
    input  logic             j_eq,
    input  logic             j_gt,
    input  logic [WIDTH-1:0] alu_r,
    output logic             jmp
);

    logic is_neg;
    logic is_zero;

    assign is_neg  = alu_r[WIDTH-1];
    assign is_zero = (alu_r == '0);
    assign jmp     = (j_lt & is_neg) | (j_eq & is_zero) | (j_gt & ~is_neg & ~is_zero);

endmodule

// File: rtl/nand_fetch_sequencer.sv
// Fetch/evaluate/write sequencer for the A/D/*A memory block.
// Fetches one 16-bit instruction over a req/ack handshake, evaluates it for
// one cycle (capturing the ALU result and jump decision) and drives the
// store strobes plus the X bus for one WRITE cycle, then advances pc.
//
// Handshake: rom_req is held high with rom_addr stable for as long as the
// sequencer sits in FETCH; the word on rom_data is taken on the first
// posedge where rom_req and rom_ack are both high. rom_ack is ignored at
// all other times.
//
// Ports:
//   cl, rst_n        : clock (posedge), asynchronous active-low reset
//   rom_req/rom_addr : fetch request and address (rom_addr == pc)
//   rom_ack/rom_data : fetch acknowledge and instruction word
//   alu_r, a_reg     : external ALU result, current A register
//   sm, alu_ctl      : ALU operand select and control, valid in EVAL/WRITE
//   a, d, addr_a     : store strobes, only ever high in WRITE
//   X                : write data, res during WRITE, 0 otherwise
//   pc               : program counter
//   halted           : high in HALT (only with HALT_ON_SELF_JUMP_EN)
//   dbg_state        : current sequencer state
//
// Build option: define HALT_ON_SELF_JUMP_EN to stop in a HALT state on an
// unconditional jump to the instruction's own address with no stores.
module nand_fetch_sequencer
    import nand_ctrl_pkg::*;
#(
    parameter int              PC_W     = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic             cl,
    input  logic             rst_n,
    output logic             rom_req,
    output logic [PC_W-1:0]  rom_addr,
    input  logic             rom_ack,
    input  logic [WIDTH-1:0] rom_data,
    input  logic [WIDTH-1:0] alu_r,
    input  logic [WIDTH-1:0] a_reg,
    output logic             sm,
    output logic [4:0]       alu_ctl,
    output logic             a,
    output logic             d,
    output logic             addr_a,
    output logic [WIDTH-1:0] X,
    output logic [PC_W-1:0]  pc,
    output logic             halted,
    output state_e           dbg_state
);

    state_e           state_q, state_d;
    logic [PC_W-1:0]  pc_q,    pc_d;
    logic [WIDTH-1:0] ir_q,    ir_d;
    logic [WIDTH-1:0] res_q,   res_d;
    logic             jmp_q,   jmp_d;
    logic [PC_W-1:0]  tgt_q,   tgt_d;
    // Low during reset and the cycle after release, so rom_req first rises
    // on the first posedge after reset is released.
    logic             req_en_q;
    logic             jmp_c;

`ifdef HALT_ON_SELF_JUMP_EN
    logic             halt_q, halt_d;
`endif

    nand_jump_cond u_jump_cond (
        .j_lt  (ir_q[J_LT]),
        .j_eq  (ir_q[J_EQ]),
        .j_gt  (ir_q[J_GT]),
        .alu_r (alu_r),
        .jmp   (jmp_c)
    );

    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            pc_q     <= RESET_PC;
            ir_q     <= '0;
            res_q    <= '0;
            jmp_q    <= 1'b0;
            tgt_q    <= '0;
            req_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            ir_q     <= ir_d;
            res_q    <= res_d;
            jmp_q    <= jmp_d;
            tgt_q    <= tgt_d;
            req_en_q <= 1'b1;
        end
    end

`ifdef HALT_ON_SELF_JUMP_EN
    always_ff @(posedge cl or negedge rst_n) begin
        if (!rst_n) begin
            halt_q <= 1'b0;
        end else begin
            halt_q <= halt_d;
        end
    end
`endif

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        ir_d    = ir_q;
        res_d   = res_q;
        jmp_d   = jmp_q;
        tgt_d   = tgt_q;
        rom_req = 1'b0;
        sm      = 1'b0;
        alu_ctl = '0;
        a       = 1'b0;
        d       = 1'b0;
        addr_a  = 1'b0;
        X       = '0;
        halted  = 1'b0;
`ifdef HALT_ON_SELF_JUMP_EN
        halt_d  = halt_q;
`endif

        case (state_q)
            FETCH: begin
                rom_req = req_en_q;
                if (req_en_q && rom_ack) begin
                    ir_d    = rom_data;
                    state_d = EVAL;
                end
            end

            EVAL: begin
                sm      = ir_q[SM];
                alu_ctl = ir_q[ALU_HI:ALU_LO];
                if (ir_q[CI]) begin
                    res_d = alu_r;
                    jmp_d = jmp_c;
                    // Target is A before this instruction's own stores land.
                    tgt_d = a_reg[PC_W-1:0];
                end else begin
                    res_d = {1'b0, ir_q[CI-1:0]};
                    jmp_d = 1'b0;
                end
`ifdef HALT_ON_SELF_JUMP_EN
                halt_d = ir_q[CI] && (ir_q[J_LT:J_GT] == 3'b111) &&
                         (ir_q[DST_A:DST_M] == 3'b000) && (a_reg[PC_W-1:0] == pc_q);
`endif
                state_d = WRITE;
            end

            WRITE: begin
                sm      = ir_q[SM];
                alu_ctl = ir_q[ALU_HI:ALU_LO];
                // X comes from the registered result so a *A write in this
                // cycle cannot feed back into the data being stored.
                X       = res_q;
                if (ir_q[CI]) begin
                    a      = ir_q[DST_A];
                    d      = ir_q[DST_D];
                    addr_a = ir_q[DST_M];
                end else begin
                    a      = 1'b1;
                end
                pc_d    = jmp_q ? tgt_q : pc_q + PC_W'(1);
`ifdef HALT_ON_SELF_JUMP_EN
                state_d = halt_q ? HALT : FETCH;
`else
                state_d = FETCH;
`endif
            end

`ifdef HALT_ON_SELF_JUMP_EN
            HALT: begin
                halted = 1'b1;
            end
`endif

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    assign rom_addr  = pc_q;
    assign pc        = pc_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_nand_fetch_sequencer.sv
module tb_nand_fetch_sequencer;
    import nand_ctrl_pkg::*;

    logic        cl;
    logic        rst_n;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] alu_r;
    logic [15:0] a_reg;
    logic        sm;
    logic [4:0]  alu_ctl;
    logic        a;
    logic        d;
    logic        addr_a;
    logic [15:0] X;
    logic [15:0] pc;
    logic        halted;
    state_e      dbg_state;

    int n_assert = 0;
    int n_fail   = 0;

    nand_fetch_sequencer #(.PC_W(16), .RESET_PC(16'h0000)) dut (
        .cl        (cl),
        .rst_n     (rst_n),
        .rom_req   (rom_req),
        .rom_addr  (rom_addr),
        .rom_ack   (rom_ack),
        .rom_data  (rom_data),
        .alu_r     (alu_r),
        .a_reg     (a_reg),
        .sm        (sm),
        .alu_ctl   (alu_ctl),
        .a         (a),
        .d         (d),
        .addr_a    (addr_a),
        .X         (X),
        .pc        (pc),
        .halted    (halted),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial cl = 1'b0;
    always #5 cl = ~cl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge cl);
        #1;
    endtask

    task automatic chk_strobes_off(input string tag);
        chk(tag, {29'd0, a, d, addr_a}, 32'd0);
    endtask

    // Present an instruction with an immediate ack, advance into EVAL.
    task automatic fetch_imm(input logic [15:0] data);
        rom_data = data;
        rom_ack  = 1'b1;
        tick();
        rom_ack  = 1'b0;
    endtask

    initial begin
        rst_n    = 1'b0;
        rom_ack  = 1'b0;
        rom_data = 16'h0000;
        alu_r    = 16'h0000;
        a_reg    = 16'h0000;

        // ---- reset state
        #12;
        chk("rst_req",   {31'd0, rom_req}, 32'd0);
        chk("rst_pc",    {16'd0, pc}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, {30'd0, FETCH});
        chk("rst_X",     {16'd0, X}, 32'd0);
        chk_strobes_off("rst_strb");
        rst_n = 1'b1;
        #1;
        chk("rel_req_low", {31'd0, rom_req}, 32'd0);
        tick();
        chk("rel_req_high", {31'd0, rom_req}, 32'd1);
        chk("rel_addr",     {16'd0, rom_addr}, 32'd0);

        // ---- data instruction 0x1234, immediate ack
        fetch_imm(16'h1234);
        chk("d1_eval",    {30'd0, dbg_state}, {30'd0, EVAL});
        chk("d1_eval_rq", {31'd0, rom_req}, 32'd0);
        chk("d1_sm",      {31'd0, sm}, 32'd1);
        chk("d1_alu_ctl", {27'd0, alu_ctl}, 32'h08);
        chk_strobes_off("d1_eval_strb");
        tick();
        chk("d1_write",   {30'd0, dbg_state}, {30'd0, WRITE});
        chk("d1_strb",    {29'd0, a, d, addr_a}, 32'b100);
        chk("d1_X",       {16'd0, X}, 32'h1234);
        tick();
        chk("d1_fetch",   {30'd0, dbg_state}, {30'd0, FETCH});
        chk("d1_addr",    {16'd0, rom_addr}, 32'h0001);
        chk("d1_X_off",   {16'd0, X}, 32'd0);

        // ---- ack withheld 3 cycles, stale data on the bus
        rom_data = 16'hBEEF;
        for (int i = 0; i < 4; i++) begin
            chk("w_req",  {31'd0, rom_req}, 32'd1);
            chk("w_addr", {16'd0, rom_addr}, 32'h0001);
            chk_strobes_off("w_strb");
            chk("w_X",    {16'd0, X}, 32'd0);
            if (i < 3) tick();
        end
        fetch_imm(16'h0055);
        chk("w_eval", {30'd0, dbg_state}, {30'd0, EVAL});
        tick();
        chk("w_X_new", {16'd0, X}, 32'h0055);
        tick();
        chk("w_next", {16'd0, rom_addr}, 32'h0002);

        // ---- compute 0x8010: D <= ALU, result registered in EVAL
        fetch_imm(16'h8010);
        alu_r = 16'hFFFF;
        tick();
        alu_r = 16'h0000;
        #1;
        chk("c_strb", {29'd0, a, d, addr_a}, 32'b010);
        chk("c_X",    {16'd0, X}, 32'hFFFF);
        tick();
        chk("c_next", {16'd0, rom_addr}, 32'h0003);

        // ---- jump-if-negative taken: 0x8004, A=0x0040, result 0x8000
        a_reg = 16'h0040;
        fetch_imm(16'h8004);
        alu_r = 16'h8000;
        tick();
        a_reg = 16'h1111;          // A changing in WRITE must not move the target
        chk_strobes_off("j1_strb");
        tick();
        chk("j1_taken", {16'd0, rom_addr}, 32'h0040);

        // ---- same instruction, positive result: not taken
        a_reg = 16'h0040;
        fetch_imm(16'h8004);
        alu_r = 16'h0001;
        tick();
        tick();
        chk("j2_not_taken", {16'd0, rom_addr}, 32'h0041);

        // ---- jump to 0xFFFF via jump-if-zero (pc != target)
        a_reg = 16'hFFFF;
        fetch_imm(16'h8007);
        alu_r = 16'h0000;
        tick();
        tick();
        chk("j3_ffff", {16'd0, rom_addr}, 32'hFFFF);
        chk("j3_halt", {31'd0, halted}, 32'd0);

        // ---- non-jump at 0xFFFF wraps to 0
        fetch_imm(16'h0003);
        tick();
        chk("wrap_X", {16'd0, X}, 32'h0003);
        tick();
        chk("wrap_addr", {16'd0, rom_addr}, 32'h0000);

        // ---- one more data instruction so pc != RESET_PC before reset
        fetch_imm(16'h0022);
        tick();
        chk("d2_X", {16'd0, X}, 32'h0022);
        tick();
        chk("d2_addr", {16'd0, rom_addr}, 32'h0001);

        // ---- reset mid-FETCH with ack pending
        rom_data = 16'h1111;
        rom_ack  = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk("ra_req",   {31'd0, rom_req}, 32'd0);
        chk("ra_pc",    {16'd0, pc}, 32'd0);
        chk("ra_state", {30'd0, dbg_state}, {30'd0, FETCH});
        tick();
        chk("ra_hold",  {30'd0, dbg_state}, {30'd0, FETCH});
        rom_ack = 1'b0;
        rst_n   = 1'b1;
        #1;
        chk("ra_req_rel", {31'd0, rom_req}, 32'd0);
        tick();
        chk("ra_req_up", {31'd0, rom_req}, 32'd1);
        chk("ra_addr",   {16'd0, rom_addr}, 32'd0);
        fetch_imm(16'h0042);
        chk("ra_eval_sm", {31'd0, sm}, 32'd0);
        tick();
        chk("ra_X",  {16'd0, X}, 32'h0042);
        tick();
        chk("ra_next", {16'd0, rom_addr}, 32'h0001);

        // ---- jump to 5, then self-jump at 5
        a_reg = 16'h0005;
        alu_r = 16'h0000;
        fetch_imm(16'h8007);
        tick();
        tick();
        chk("sj_at5", {16'd0, rom_addr}, 32'h0005);
        fetch_imm(16'h8007);
        tick();
        chk_strobes_off("sj_strb");
        tick();
`ifdef HALT_ON_SELF_JUMP_EN
        chk("sj_halted", {31'd0, halted}, 32'd1);
        chk("sj_state",  {30'd0, dbg_state}, {30'd0, HALT});
        rom_ack = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("sj_req_off", {31'd0, rom_req}, 32'd0);
            chk("sj_pc",      {16'd0, pc}, 32'h0005);
            tick();
        end
        rom_ack = 1'b0;
`else
        chk("sj_halted", {31'd0, halted}, 32'd0);
        for (int i = 0; i < 2; i++) begin
            chk("sj_refetch", {16'd0, rom_addr}, 32'h0005);
            chk("sj_req",     {31'd0, rom_req}, 32'd1);
            fetch_imm(16'h8007);
            chk("sj_eval", {30'd0, dbg_state}, {30'd0, EVAL});
            tick();
            chk("sj_write", {30'd0, dbg_state}, {30'd0, WRITE});
            tick();
        end
        chk("sj_final", {16'd0, rom_addr}, 32'h0005);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/nand_fetch_sequencer.md
Name: nand_fetch_sequencer

Overview:
- Upstream control stage for the A/D/*A combined-memory block.
- Fetches 16-bit instructions from an instruction ROM over a req/ack handshake and sequences each instruction through EVAL and WRITE cycles.
- Drives the memory block's store strobes (a, d, addr_a) and data bus X.
- Owns the program counter and jump evaluation. The ALU is external and combinational.

Parameters:
- PC_W, 16: program counter and ROM address width.
- RESET_PC, 0: PC value loaded on reset.

Ports:
- cl  in  1  clock; all state updates on posedge.
- rst_n  in  1  reset; asynchronous, active-low.
- rom_req  out  1  fetch request.
- rom_addr  out  PC_W  fetch address; always equals pc.
- rom_ack  in  1  ROM data valid; sampled only in FETCH.
- rom_data  in  16  instruction word.
- alu_r  in  16  external ALU result, computed from D and (sm ? *A : A).
- a_reg  in  16  current A register value from the memory stage.
- sm  out  1  ALU operand select = ir[12].
- alu_ctl  out  5  {u,op1,op0,zx,sw} = ir[10:6].
- a, d, addr_a  out  1  store strobes to the memory stage.
- X  out  16  write data to the memory stage.
- pc  out  PC_W  current program counter.
- halted  out  1  halt indicator; constant 0 unless the macro is enabled.

Behaviour:
- Reset (rst_n low, takes effect immediately):
  - state=FETCH, pc=RESET_PC, ir=0, res=0, jmp=0.
  - All strobes 0, X=0, rom_req=0.
  - rom_req asserts on the first posedge after release.
- FETCH:
  - rom_req=1, rom_addr=pc, strobes 0.
  - Wait indefinitely for rom_ack; rom_addr must stay stable while waiting.
  - On a posedge with rom_ack=1: ir<=rom_data, go to EVAL.
  - rom_ack outside FETCH is ignored.
- EVAL (one cycle, strobes 0, rom_req=0):
  - sm and alu_ctl are driven from ir while in EVAL and WRITE; they are 0 in FETCH.
  - If ir[15]=0 (data instruction): res<={1'b0,ir[14:0]}, jmp<=0.
  - If ir[15]=1 (compute instruction): res<=alu_r.
    - jmp <= (ir[2] & alu_r[15]) | (ir[1] & alu_r==0) | (ir[0] & ~alu_r[15] & alu_r!=0). alu_r is treated as signed.
    - tgt<=a_reg. The jump target is A as it was before this instruction's writes.
  - Go to WRITE.
- WRITE (one cycle):
  - X=res.
  - Data instruction: a=1, d=0, addr_a=0.
  - Compute instruction: a=ir[5], d=ir[4], addr_a=ir[3].
  - At the posedge: pc <= jmp ? tgt[PC_W-1:0] : pc+1, then go to FETCH.
- Why the registered result: res is registered, so the memory stage's negedge *A write cannot disturb X within WRITE.
- PC wrap: pc+1 wraps from all-ones to 0 silently.
- Strobe gating: all strobes are 0 outside WRITE. No strobe ever asserts in FETCH or EVAL.
- Instruction period: 3 cycles plus ROM wait cycles. There is no pipelining or overlap.
- Simultaneous events: rst_n low during any state, including WRITE, aborts that state with no partial pc update.

Optional Feature:
- Macro: HALT_ON_SELF_JUMP_EN.
- With the macro:
  - In EVAL, detect ir[15]=1, ir[2:0]=3'b111, ir[5:3]=0 and a_reg==pc.
  - If detected, WRITE goes to HALT instead of FETCH.
  - HALT: halted=1, rom_req=0, strobes 0, pc frozen. Exit only by reset.
- Without the macro: no HALT state; halted tied 0; a self-jump loops forever through FETCH.

Decomposition:
- Package nand_ctrl_pkg holds:
  - state enum {FETCH, EVAL, WRITE, HALT}
  - instruction field bit positions (CI=15, SM=12, ALU_HI=10, ALU_LO=6, DST_A=5, DST_D=4, DST_M=3, J_LT=2, J_EQ=1, J_GT=0)
  - width 16
- Sub-module nand_jump_cond: combinational jmp from {lt,eq,gt} and alu_r. It is reused by the behavioural CPU model.

Test Plan:
- Reset, then rom_data=16'h1234 with immediate ack: EVAL next cycle; WRITE shows a=1, d=0, addr_a=0, X=16'h1234; next FETCH has rom_addr=1.
- rom_ack withheld 3 cycles: rom_req=1 and rom_addr constant for all 4 cycles; strobes 0; stale rom_data before ack never reaches X.
- rom_data=16'h8010, alu_r=16'hFFFF in EVAL, alu_r changed to 0 during WRITE: d=1, a=0, addr_a=0, X=16'hFFFF; pc+1.
- rom_data=16'h8004, a_reg=16'h0040: alu_r=16'h8000 gives next rom_addr=16'h0040; repeated with alu_r=16'h0001 gives pc+1. Also set pc=16'hFFFF with a non-jump instruction: next rom_addr=16'h0000.
- rst_n low mid-FETCH with ack pending: rom_req drops with no clock edge; after release pc=RESET_PC and ir is not loaded.
- HALT_ON_SELF_JUMP_EN defined, pc=5, rom_data=16'h8007, a_reg=5: halted=1 after WRITE; rom_req stays 0 for 10 cycles. Same stimulus without the macro: re-fetch of address 5 every 3 cycles.
